// File: rtl/i2s_tx_out.sv
// i2s_tx_out -- I2S transmitter with a small stereo frame FIFO.
//
// Takes stereo frames from the DSP core on a valid/ready handshake, buffers
// them, and serializes them as Philips I2S (MSB first, one BCLK of data
// delay after each LRCLK edge). BCLK and LRCLK are generated from sys_clk.
//
// Ports:
//   sys_clk, sys_rst_n     clock, asynchronous active-low reset
//   enable                 run the serial output
//   in_left/in_right       parallel samples (AUDIO_WIDTH)
//   in_valid/in_ready      frame handshake (ready = FIFO not full)
//   i2s_bclk/lrclk/data    serial interface toward the DAC
//   fifo_level             frames currently stored
//   underrun               sticky: a frame start found the FIFO empty
//   frame_start            one-cycle pulse at each frame start
//
// Build option:
//   I2S_TX_OUT_REPEAT_ON_UNDERRUN_EN -- when defined, an empty FIFO at a
//   frame start repeats the last frame instead of sending zeros.
module i2s_tx_out #(
  parameter int I2S_WIDTH   = 24,
  parameter int AUDIO_WIDTH = 24,
  parameter int BCLK_DIV    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          enable,
  input  logic [AUDIO_WIDTH-1:0]        in_left,
  input  logic [AUDIO_WIDTH-1:0]        in_right,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          frame_start
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(2 * I2S_WIDTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * I2S_WIDTH - 1);
  localparam logic [BW-1:0] SLOT     = BW'(I2S_WIDTH);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic [I2S_WIDTH-1:0] l;
    logic [I2S_WIDTH-1:0] r;
  } frame_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  frame_t          mem [FIFO_DEPTH];
  frame_t          in_frame;
  frame_t          hold;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   div_cnt;
  logic [BW-1:0]   bit_idx;

  logic            push, pop, fall, wrap, start, stop, ser;
  logic [BW-1:0]   nxt_bit;
  logic [I2S_WIDTH-1:0] shifted;

  // Left-justify samples into the slot width.
  if (AUDIO_WIDTH >= I2S_WIDTH) begin : g_trunc
    assign in_frame.l = in_left[AUDIO_WIDTH-1 -: I2S_WIDTH];
    assign in_frame.r = in_right[AUDIO_WIDTH-1 -: I2S_WIDTH];
  end else begin : g_pad
    assign in_frame.l = {in_left,  {(I2S_WIDTH-AUDIO_WIDTH){1'b0}}};
    assign in_frame.r = {in_right, {(I2S_WIDTH-AUDIO_WIDTH){1'b0}}};
  end

  assign in_ready = (fifo_level != FULL);
  assign push     = in_valid && in_ready;

  // A fall event is the divider wrap; from idle, enable itself makes the
  // very next edge a fall event so the first frame starts immediately.
  assign wrap  = (bit_idx == BIT_LAST);
  assign fall  = (state == RUN) ? (div_cnt == DIV_LAST) : enable;
  assign start = fall && enable && ((state == IDLE) || wrap);
  assign stop  = (state == RUN) && fall && wrap && !enable;
  assign pop   = start && (fifo_level != '0);

  assign nxt_bit = start ? '0 : bit_idx + BIT_ONE;

  // Serial bit for the BCLK period that begins at nxt_bit. Position 0 of a
  // slot carries the LSB of the preceding slot's word; after idle there is
  // no preceding word, so it is 0.
  always_comb begin
    shifted = '0;
    ser     = 1'b0;
    if (nxt_bit == '0) begin
      ser = (state == RUN) ? hold.r[0] : 1'b0;
    end else if (nxt_bit == SLOT) begin
      ser = hold.l[0];
    end else if (nxt_bit < SLOT) begin
      shifted = hold.l >> (SLOT - nxt_bit);
      ser     = shifted[0];
    end else begin
      shifted = hold.r >> ((BIT_LAST - nxt_bit) + BIT_ONE);
      ser     = shifted[0];
    end
  end

  // Storage needs no reset: level and pointers define what is valid.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= in_frame;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      div_cnt     <= '0;
      bit_idx     <= '0;
      hold        <= '0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_data    <= 1'b0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_level <= fifo_level + LVL_ONE;
      else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;

      if (state == IDLE) underrun <= 1'b0;

      if (start) begin
        frame_start <= 1'b1;
        state       <= RUN;
        if (pop) begin
          hold <= mem[rd_ptr];
        end else begin
          underrun <= 1'b1;
`ifdef I2S_TX_OUT_REPEAT_ON_UNDERRUN_EN
          hold <= hold;  // last frame goes out again
`else
          hold <= '0;
`endif
        end
      end

      if (stop || ((state == IDLE) && !enable)) begin
        state     <= IDLE;
        div_cnt   <= '0;
        bit_idx   <= '0;
        i2s_bclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_data  <= 1'b0;
      end else if (fall) begin
        // Data and word select move only here, half a BCLK before the
        // rising edge the receiver samples on.
        div_cnt   <= '0;
        bit_idx   <= nxt_bit;
        i2s_bclk  <= 1'b0;
        i2s_lrclk <= (nxt_bit >= SLOT);
        i2s_data  <= ser;
      end else begin
        div_cnt  <= div_cnt + DIV_ONE;
        i2s_bclk <= ((div_cnt + DIV_ONE) >= DIV_HALF);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_out.sv
// Bench for i2s_tx_out: a frame-level reference model (queue of frames,
// time-since-frame-start counter) is compared with two DUTs every cycle,
// one with 24-bit samples and one with 16-bit samples fed from the top
// 16 bits of the same stimulus. Directed tests add literal expectations.
module tb_i2s_tx_out;

  localparam int W     = 24;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int FR    = DIV * 2 * W;
  localparam logic [23:0] MASK16 = 24'hFFFF00;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable    = 1'b0;
  logic        in_valid  = 1'b0;
  logic [23:0] in_left   = '0;
  logic [23:0] in_right  = '0;

  logic       in_ready, i2s_bclk, i2s_lrclk, i2s_data, underrun, frame_start;
  logic [2:0] fifo_level;
  logic       ready16, bclk16, lrclk16, data16, underrun16, fs16;
  logic [2:0] level16;

  i2s_tx_out #(.I2S_WIDTH(24), .AUDIO_WIDTH(24), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_data(i2s_data), .fifo_level(fifo_level), .underrun(underrun),
    .frame_start(frame_start));

  i2s_tx_out #(.I2S_WIDTH(24), .AUDIO_WIDTH(16), .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut16 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .in_left(in_left[23:8]), .in_right(in_right[23:8]), .in_valid(in_valid),
    .in_ready(ready16), .i2s_bclk(bclk16), .i2s_lrclk(lrclk16),
    .i2s_data(data16), .fifo_level(level16), .underrun(underrun16),
    .frame_start(fs16));

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [23:0] q_l[$], q_r[$];
  logic [23:0] cur_l, cur_r, prev_r;
  int          t;
  bit          run_m, und_m, fs_m;

  initial begin
    bit push_ok, start;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        q_l.delete(); q_r.delete();
        cur_l = '0; cur_r = '0; prev_r = '0;
        t = 0; run_m = 0; und_m = 0; fs_m = 0;
      end else begin
        push_ok = in_valid && (q_l.size() < DEPTH);
        start   = 0;
        fs_m    = 0;
        if (!run_m) begin
          und_m = 0;
          if (enable) begin
            start = 1; run_m = 1; t = 0; prev_r = '0;
          end
        end else begin
          t++;
          if (t == FR) begin
            t = 0;
            if (enable) begin
              start = 1; prev_r = cur_r;
            end else begin
              run_m = 0;
            end
          end
        end
        if (start) begin
          fs_m = 1;
          if (q_l.size() > 0) begin
            cur_l = q_l.pop_front();
            cur_r = q_r.pop_front();
          end else begin
            und_m = 1;
`ifndef I2S_TX_OUT_REPEAT_ON_UNDERRUN_EN
            cur_l = '0; cur_r = '0;
`endif
          end
        end
        if (push_ok) begin
          q_l.push_back(in_left);
          q_r.push_back(in_right);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int k, ph, p, bp;
    logic [23:0] word, w16;
    logic e_bclk, e_lr, e_d, e_d16, e_rdy;
    logic [2:0] e_lvl;
    forever begin
      @(negedge sys_clk);
      e_bclk = 0; e_lr = 0; e_d = 0; e_d16 = 0;
      if (run_m) begin
        k  = t / DIV;
        ph = t % DIV;
        p  = k % W;
        e_bclk = (ph >= DIV / 2);
        e_lr   = (k >= W);
        if (p == 0) word = (k == 0) ? prev_r : cur_l;
        else        word = (k < W) ? cur_l : cur_r;
        bp    = (p == 0) ? 0 : W - p;
        w16   = word & MASK16;
        e_d   = word[bp];
        e_d16 = w16[bp];
      end
      e_rdy = (q_l.size() < DEPTH);
      e_lvl = 3'(q_l.size());
      check("outputs24", {i2s_bclk, i2s_lrclk, i2s_data, in_ready, fifo_level, underrun, frame_start},
                         {e_bclk, e_lr, e_d, e_rdy, e_lvl, und_m, fs_m});
      check("outputs16", {bclk16, lrclk16, data16, ready16, level16, underrun16, fs16},
                         {e_bclk, e_lr, e_d16, e_rdy, e_lvl, und_m, fs_m});
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [23:0] l, input logic [23:0] r);
    in_valid = 1'b1; in_left = l; in_right = r;
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge sys_clk);
      if (frame_start) return;
    end
    timeout(name);
  endtask

  // Collects the 48 bits seen on BCLK rising edges from the 2nd BCLK of the
  // frame through the 1st BCLK of the next one, plus LRCLK slot counts.
  task automatic capture(output logic [47:0] w, output logic [47:0] w16,
                         output int lo, output int hi);
    int r;
    logic pb;
    w = '0; w16 = '0; lo = 0; hi = 0; r = 0; pb = 1'b0;
    wait_fs("capture start");
    for (int c = 0; c < FR + 20 && r < 49; c++) begin
      @(negedge sys_clk);
      if (i2s_bclk && !pb) begin
        if (r < 48) begin
          if (i2s_lrclk) hi++; else lo++;
        end
        if (r >= 1) begin
          w   = {w[46:0], i2s_data};
          w16 = {w16[46:0], data16};
        end
        r++;
      end
      pb = i2s_bclk;
    end
    if (r < 49) timeout("capture bits");
  endtask

  initial begin
    logic [47:0] w, w16;
    int lo, hi;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("reset state", {i2s_bclk, i2s_lrclk, i2s_data, fifo_level, underrun, frame_start, in_ready},
                         {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Single frame, serial order and LRCLK slots
    push(24'hA5A5A5, 24'h5A5A5A);
    check("t1 level", fifo_level, 64'd1);
    enable = 1'b1;
    capture(w, w16, lo, hi);
    check("t1 serial word", w, 64'hA5A5A5_5A5A5A);
    check("t1 lrclk low bclks", lo, 64'd24);
    check("t1 lrclk high bclks", hi, 64'd24);
    check("t1 underrun 2nd frame", underrun, 64'd1);
    enable = 1'b0;
    repeat (FR + 10) @(negedge sys_clk);
    check("t1 idle underrun cleared", underrun, 64'd0);

    // FIFO full, refused 5th frame, drain
    push(24'hC0FFEE, 24'h0BEEF0);
    push(24'h123456, 24'hFEDCBA);
    push(24'h800001, 24'h7FFFFE);
    push(24'hFFFFFF, 24'h000000);
    check("t2 full level", fifo_level, 64'd4);
    check("t2 full ready", in_ready, 64'd0);
    push(24'hDEAD00, 24'h00BEEF);
    check("t2 5th refused", fifo_level, 64'd4);
    enable = 1'b1;
    wait_fs("t2 fs1");
    check("t2 level after fs1", fifo_level, 64'd3);
    wait_fs("t2 fs2");
    wait_fs("t2 fs3");
    wait_fs("t2 fs4");
    check("t2 level after fs4", fifo_level, 64'd0);
    enable = 1'b0;
    repeat (FR + 10) @(negedge sys_clk);

    // Underrun from an empty FIFO, then one frame, then repeat/zeros
    enable = 1'b1;
    wait_fs("t3 fs1");
    check("t3 underrun", underrun, 64'd1);
    push(24'h123456, 24'h654321);
    wait_fs("t3 fs2");
    check("t3 level popped", fifo_level, 64'd0);
    wait_fs("t3 fs3");
    check("t3 underrun sticky", underrun, 64'd1);
    enable = 1'b0;
    repeat (FR + 10) @(negedge sys_clk);

    // 16-bit samples left-justified into 24-bit slots
    push(24'h800100, 24'h00FF00);
    enable = 1'b1;
    capture(w, w16, lo, hi);
    check("t4 16-bit slot words", w16, 64'h800100_00FF00);
    check("t4 24-bit slot words", w, 64'h800100_00FF00);
    enable = 1'b0;
    repeat (FR + 10) @(negedge sys_clk);

    // Stop mid-frame: frame completes, no pop at the boundary
    push(24'h0F0F0F, 24'hF0F0F0);
    push(24'h3C3C3C, 24'hC3C3C3);
    enable = 1'b1;
    wait_fs("t5 fs");
    check("t5 level after fs", fifo_level, 64'd1);
    repeat (10 * DIV) @(negedge sys_clk);
    enable = 1'b0;
    repeat (FR) @(negedge sys_clk);
    check("t5 no pop at stop", fifo_level, 64'd1);
    check("t5 idle clocks", {i2s_bclk, i2s_lrclk, i2s_data}, 64'd0);

    // Asynchronous reset mid-frame
    enable = 1'b1;
    wait_fs("t6 fs");
    push(24'h555555, 24'hAAAAAA);
    check("t6 level before reset", fifo_level, 64'd1);
    repeat (60) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t6 async reset", {i2s_bclk, i2s_lrclk, i2s_data, fifo_level, underrun, frame_start, in_ready},
                            {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
    enable = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
